nfu_tile_sequencer: RTL and testbench

Control sequencer for the NFU-1 stage: on a start command, it walks the output-tile by input-tile loop nest for one layer. Each cycle it issues NBin and SB read enables and addresses, so that a Tn input vector and a TnxTn synapse block enter the NFU-1 pipeline. A PIPE_LAT-deep tag pipeline re-times accumulator-clear and NBout-write strobes to match the datapath latency. A global stall freezes issue and tags together.

---
 rtl/nfu_tile_sequencer.sv | 151 +++++++++++++++
 tb/tb_nfu_tile_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nfu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nfu_tile_sequencer
// Brief    : NFU-1 loop-nest sequencer issuing NBin/SB reads with a re-timed
//            tag pipe for accumulator-clear and NBout-write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module nfu_tile_sequencer #(
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_in_tiles,
    input  logic [CNT_W-1:0]  i_num_out_tiles,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_nbin_rd_en,
    output logic [ADDR_W-1:0] o_nbin_addr,
    output logic              o_sb_rd_en,
    output logic [ADDR_W-1:0] o_sb_addr,
    output logic              o_acc_clear,
    output logic              o_out_wr_en,
    output logic [CNT_W-1:0]  o_out_addr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [CNT_W-1:0] outIdx;
    } tag_t;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_numIn;
    logic [CNT_W-1:0]  r_numOut;
    logic [CNT_W-1:0]  r_inIdx;
    logic [CNT_W-1:0]  r_outIdx;
    logic [ADDR_W-1:0] r_sbAddr;
    tag_t              r_tag [PIPE_LAT];

    logic w_issue;
    logic w_lastIn;
    logic w_lastOut;
    logic w_pendingAfterShift;
    tag_t w_pushTag;
    tag_t w_tail;

    assign w_issue   = (r_state == c_ISSUE) && !i_stall;
    assign w_lastIn  = (r_inIdx == r_numIn - 1'b1);
    assign w_lastOut = (r_outIdx == r_numOut - 1'b1);
    assign w_tail    = r_tag[PIPE_LAT-1];

    always_comb begin
        w_pushTag        = '0;
        w_pushTag.valid  = w_issue;
        w_pushTag.first  = w_issue && (r_inIdx == '0);
        w_pushTag.last   = w_issue && w_lastIn;
        w_pushTag.outIdx = w_issue ? r_outIdx : '0;
    end

    // Anything valid outside the tail survives the next shift, so drain is not yet over.
    always_comb begin
        w_pendingAfterShift = 1'b0;
        for (int k = 0; k < PIPE_LAT - 1; k++) begin
            w_pendingAfterShift = w_pendingAfterShift | r_tag[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_numIn  <= '0;
            r_numOut <= '0;
            r_inIdx  <= '0;
            r_outIdx <= '0;
            r_sbAddr <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        if ((i_num_in_tiles != '0) && (i_num_out_tiles != '0)) begin
                            r_numIn  <= i_num_in_tiles;
                            r_numOut <= i_num_out_tiles;
                            r_inIdx  <= '0;
                            r_outIdx <= '0;
                            r_sbAddr <= '0;
                            r_state  <= c_ISSUE;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (!i_stall) begin
                        r_sbAddr <= r_sbAddr + 1'b1;
                        if (w_lastIn) begin
                            r_inIdx  <= '0;
                            r_outIdx <= r_outIdx + 1'b1;
                            if (w_lastOut) begin
                                r_state <= c_DRAIN;
                            end
                        end else begin
                            r_inIdx <= r_inIdx + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (!i_stall && !w_pendingAfterShift) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else if (!i_stall) begin
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                r_tag[k] <= r_tag[k-1];
            end
            r_tag[0] <= w_pushTag;
        end
    end

    assign o_busy       = (r_state == c_ISSUE) || (r_state == c_DRAIN);
    assign o_done       = (r_state == c_DONE);
    assign o_nbin_rd_en = w_issue;
    assign o_sb_rd_en   = w_issue;
    assign o_nbin_addr  = ADDR_W'(r_inIdx);
    assign o_sb_addr    = r_sbAddr;
    assign o_acc_clear  = !i_stall && w_tail.valid && w_tail.first;
    assign o_out_wr_en  = !i_stall && w_tail.valid && w_tail.last;
    assign o_out_addr   = i_stall ? '0 : w_tail.outIdx;

endmodule
`default_nettype wire

// File: tb/tb_nfu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfu_tile_sequencer
// Brief    : Directed and randomized layers for nfu_tile_sequencer, checked
//            against a per-read timestamp model of the tile loop nest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nfu_tile_sequencer;

    localparam int CNT_W    = 8;
    localparam int ADDR_W   = 16;
    localparam int PIPE_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_num_in_tiles;
    logic [CNT_W-1:0]  i_num_out_tiles;
    logic              i_stall;
    logic              o_busy;
    logic              o_done;
    logic              o_nbin_rd_en;
    logic [ADDR_W-1:0] o_nbin_addr;
    logic              o_sb_rd_en;
    logic [ADDR_W-1:0] o_sb_addr;
    logic              o_acc_clear;
    logic              o_out_wr_en;
    logic [CNT_W-1:0]  o_out_addr;

    nfu_tile_sequencer #(
        .CNT_W   (CNT_W),
        .ADDR_W  (ADDR_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_num_in_tiles (i_num_in_tiles),
        .i_num_out_tiles(i_num_out_tiles),
        .i_stall        (i_stall),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_nbin_rd_en   (o_nbin_rd_en),
        .o_nbin_addr    (o_nbin_addr),
        .o_sb_rd_en     (o_sb_rd_en),
        .o_sb_addr      (o_sb_addr),
        .o_acc_clear    (o_acc_clear),
        .o_out_wr_en    (o_out_wr_en),
        .o_out_addr     (o_out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int age;
        bit first;
        bit last;
        int outIdx;
    } mtag_t;

    int    checks   = 0;
    int    failures = 0;
    mtag_t q[$];
    bit    mBusy, mDone;
    int    mIssued, mTotal, mNin;
    bit    sawDone;
    int    rdCnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cyc(input bit rs, input bit st, input bit sl);
        bit    expRd, expClr, expWr, nDone;
        int    expOA;
        mtag_t t;
        rst_n   = rs;
        i_start = st;
        i_stall = sl;
        @(negedge clk);
        expRd  = mBusy && (mIssued < mTotal) && !sl;
        expClr = 1'b0;
        expWr  = 1'b0;
        expOA  = 0;
        if (!sl) begin
            foreach (q[k]) q[k].age++;
            if (q.size() > 0 && q[0].age == PIPE_LAT) begin
                expClr = q[0].first;
                expWr  = q[0].last;
                expOA  = q[0].outIdx;
                void'(q.pop_front());
            end
        end
        chk("busy", 32'(o_busy), 32'(mBusy));
        chk("done", 32'(o_done), 32'(mDone));
        chk("nbin_rd_en", 32'(o_nbin_rd_en), 32'(expRd));
        chk("sb_rd_en", 32'(o_sb_rd_en), 32'(expRd));
        if (expRd) begin
            chk("nbin_addr", 32'(o_nbin_addr), 32'(mIssued % mNin));
            chk("sb_addr", 32'(o_sb_addr), 32'(mIssued));
        end
        chk("acc_clear", 32'(o_acc_clear), 32'(expClr));
        chk("out_wr_en", 32'(o_out_wr_en), 32'(expWr));
        if (expWr) chk("out_addr", 32'(o_out_addr), 32'(expOA));
        if (o_done === 1'b1) sawDone = 1'b1;
        if (o_nbin_rd_en === 1'b1) rdCnt++;

        if (expRd) begin
            t.age    = 0;
            t.first  = (mIssued % mNin) == 0;
            t.last   = (mIssued % mNin) == mNin - 1;
            t.outIdx = mIssued / mNin;
            q.push_back(t);
            mIssued++;
        end
        nDone = 1'b0;
        if (mBusy && mIssued == mTotal && q.size() == 0) begin
            nDone = 1'b1;
            mBusy = 1'b0;
        end else if (!mBusy && !mDone && st) begin
            if (i_num_in_tiles != 0 && i_num_out_tiles != 0) begin
                mBusy   = 1'b1;
                mNin    = int'(i_num_in_tiles);
                mTotal  = int'(i_num_in_tiles) * int'(i_num_out_tiles);
                mIssued = 0;
            end else begin
                nDone = 1'b1;
            end
        end
        mDone = nDone;
        if (!rs) begin
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mIssued = 0;
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit bitAt(input logic [31:0] m, input int c);
        return (c < 32) ? m[c] : 1'b0;
    endfunction

    // expDone: >=0 exact relative done cycle, -1 done required, -2 no requirement.
    task automatic run_layer(input int nin, input int nout, input logic [31:0] stallM,
                             input logic [31:0] startM, input logic [31:0] rstM,
                             input int expDone, input int expReads, input int maxCyc);
        int doneRel;
        i_num_in_tiles  = CNT_W'(nin);
        i_num_out_tiles = CNT_W'(nout);
        sawDone = 1'b0;
        rdCnt   = 0;
        doneRel = -1;
        for (int c = 0; c < maxCyc; c++) begin
            cyc(!bitAt(rstM, c), bitAt(startM, c), bitAt(stallM, c));
            if (sawDone) begin
                doneRel = c;
                break;
            end
        end
        if (expDone >= -1) chk("done_seen", 32'(sawDone), 32'd1);
        if (expDone >= 0)  chk("done_cycle", 32'(doneRel), 32'(expDone));
        if (expReads >= 0) chk("read_count", 32'(rdCnt), 32'(expReads));
    endtask

    initial begin
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_stall         = 1'b0;
        i_num_in_tiles  = '0;
        i_num_out_tiles = '0;
        mBusy   = 1'b0;
        mDone   = 1'b0;
        mIssued = 0;
        mTotal  = 0;
        mNin    = 1;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_nbin_addr", 32'(o_nbin_addr), 32'd0);
        chk("rst_sb_addr", 32'(o_sb_addr), 32'd0);
        chk("rst_out_addr", 32'(o_out_addr), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);

        // Basic layer, then back-to-back stalled layer
        run_layer(3, 2, 32'h0, 32'h1, 32'h0, 10, 6, 40);
        run_layer(3, 2, 32'h18, 32'h1, 32'h0, 12, 6, 40);
        // Single input tile
        run_layer(1, 4, 32'h0, 32'h1, 32'h0, 8, 4, 40);
        // Zero count
        run_layer(0, 5, 32'h0, 32'h1, 32'h0, 1, 0, 10);
        run_layer(2, 0, 32'h0, 32'h1, 32'h0, 1, 0, 10);
        // Reset mid-layer then restart
        run_layer(3, 2, 32'h0, 32'h1, 32'h8, -2, -1, 5);
        chk("mid_rst_nbin_addr", 32'(o_nbin_addr), 32'd0);
        chk("mid_rst_sb_addr", 32'(o_sb_addr), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        run_layer(3, 2, 32'h0, 32'h1, 32'h0, 10, 6, 40);
        // Start while busy is ignored
        run_layer(3, 2, 32'h0, 32'h11, 32'h0, 10, 6, 40);
        // Stall during drain on the final tag
        run_layer(2, 2, 32'h1C0, 32'h1, 32'h0, 11, 4, 40);

        for (int n = 0; n < 25; n++) begin
            int ni, no;
            logic [31:0] sm, stm;
            ni  = int'($urandom_range(0, 4));
            no  = int'($urandom_range(0, 4));
            sm  = $urandom & $urandom & 32'hFFFF_FFFE;
            stm = ($urandom & $urandom) | 32'h1;
            run_layer(ni, no, sm, stm, 32'h0, -1, ni * no, 200);
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
